regfile_wb_scheduler: RTL and testbench

Write-back scheduler for the 32-entry register file. It arbitrates the register file's single write port among `NUM_SRC` write-back sources (ALU, LSU, DSP MAC) using round-robin. It keeps a pending-write scoreboard so decode can detect RAW hazards and avoid issuing WAW conflicts. It sits between the execute units and the register file's `we`/`waddr`/`wdata` inputs.

---
 rtl/rf_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/regfile_wb_scheduler.sv | 94 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Source indices name the execute units wired to the scheduler's request ports.
package rf_sched_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_DSP = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from an internal pointer,
// which moves past the granted requester whenever the grant is consumed.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx_hi;
  logic [PW-1:0] idx_lo;
  logic          found_hi;
  logic          found_lo;

  // First requester at or above ptr wins; otherwise wrap to the lowest requester.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (i >= int'(ptr)) && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = PW'(i);
      end
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = PW'(i);
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
    gnt     = found_lo ? (N'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register file's single write port among write-back sources and
// tracks in-flight destinations so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = rf_sched_pkg::XLEN,
  parameter int AW      = rf_sched_pkg::REG_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*AW-1:0]   src_rd,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_ready,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [(1<<AW)-1:0]      pending,
  output logic                    err_unexp_wb
);

  localparam int NREG = 1 << AW;

  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] fire;
  logic               xfer;
  logic               issue_fire;
  logic [AW-1:0]      sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [NREG-1:0]    pending_nxt;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (src_valid),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign src_ready = rst ? '0 : gnt;
  assign fire      = src_valid & src_ready;
  assign xfer      = |fire;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fire[i]) begin
        sel_rd   = src_rd[i*AW +: AW];
        sel_data = src_data[i*XLEN +: XLEN];
      end
    end
  end

  assign issue_ready = ~rst & ((issue_rd == '0) | ~pending[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);
  assign rs1_busy    = pending[rs1_addr] & (rs1_addr != '0);
  assign rs2_busy    = pending[rs2_addr] & (rs2_addr != '0);

  // Clear is applied before set so a same-edge issue to the retiring register wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) pending_nxt[rf_waddr] = 1'b0;
    if (issue_fire) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      pending      <= '0;
      err_unexp_wb <= 1'b0;
    end else begin
      rf_we   <= xfer & (sel_rd != '0);
      pending <= pending_nxt;
      if (xfer) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
      if (xfer && (sel_rd != '0) && !pending[sel_rd]) err_unexp_wb <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_regfile_wb_scheduler;

  localparam int NSRC = 3;
  localparam int XL   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC*AW-1:0] src_rd;
  logic [NSRC*XL-1:0] src_data;
  logic [NSRC-1:0]   src_ready;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [XL-1:0]     rf_wdata;
  logic [31:0]       pending;
  logic              err_unexp_wb;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  int          mptr;
  logic [31:0] mpend;
  logic        merr;
  logic        mwe;
  logic [4:0]  mwaddr;
  logic [31:0] mwdata;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NUM_SRC(NSRC), .XLEN(XL), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_rd       (src_rd),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending      (pending),
    .err_unexp_wb (err_unexp_wb)
  );

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NSRC; k++) begin
      if (src_valid[(mptr + k) % NSRC]) return (mptr + k) % NSRC;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int          g;
    logic [31:0] nxt;
    logic [4:0]  rd;
    if (rst) begin
      mptr = 0; mpend = '0; merr = 1'b0; mwe = 1'b0; mwaddr = '0; mwdata = '0;
    end else begin
      g   = model_grant();
      nxt = mpend;
      if (mwe) nxt[mwaddr] = 1'b0;
      if (issue_valid && issue_rd != 0 && !mpend[issue_rd]) nxt[issue_rd] = 1'b1;
      if (g >= 0) begin
        rd = src_rd[g*AW +: AW];
        if (rd != 0 && !mpend[rd]) merr = 1'b1;
        mwe    = (rd != 0);
        mwaddr = rd;
        mwdata = src_data[g*XL +: XL];
        mptr   = (g + 1) % NSRC;
      end else begin
        mwe = 1'b0;
      end
      mpend = nxt;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]         = v;
    src_rd[i*AW +: AW]   = rd;
    src_data[i*XL +: XL] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; issue_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4; rs1_addr = '0; rs2_addr = '0;
    src_rd = '0; src_data = '0;
    applyStimulus(0, 1'b1, 5'd1, 32'h11);
    applyStimulus(1, 1'b1, 5'd2, 32'h22);
    applyStimulus(2, 1'b1, 5'd3, 32'h33);
    #2;
    tests_run++; if (src_ready !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_src_ready: got %b expected 000", src_ready); end
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_issue_ready: got %b expected 0", issue_ready); end
    cycle();
    cycle();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rf_we: got %b expected 0", rf_we); end
    tests_run++; if (pending !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pending: got %h expected 0", pending); end
    tests_run++; if (err_unexp_wb !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err_unexp_wb); end
    tests_run++; if ({rf_waddr, rf_wdata} !== '0) begin tests_failed++; $display("[TB] FAIL reset_wb_regs: got %h/%h expected 0/0", rf_waddr, rf_wdata); end
    rst = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++) begin
      #2;
      tests_run++; if (src_ready !== 3'(1 << (k % 3))) begin tests_failed++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, src_ready, 3'(1 << (k % 3))); end
      cycle();
      tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_we[%0d]: got %b expected 1", k, rf_we); end
      tests_run++; if (rf_waddr !== 5'((k % 3) + 1)) begin tests_failed++; $display("[TB] FAIL rr_waddr[%0d]: got %0d expected %0d", k, rf_waddr, (k % 3) + 1); end
      tests_run++; if (rf_wdata !== 32'h11 * ((k % 3) + 1)) begin tests_failed++; $display("[TB] FAIL rr_wdata[%0d]: got %h expected %h", k, rf_wdata, 32'h11 * ((k % 3) + 1)); end
    end
    src_valid = '0;
    cycle();
  endtask

  task automatic test_scoreboard();
    do_reset();
    rs1_addr = 5'd5; issue_valid = 1'b1; issue_rd = 5'd5;
    #2;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_issue_free: got %b expected 1", issue_ready); end
    tests_run++; if (rs1_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_busy_before: got %b expected 0", rs1_busy); end
    cycle();
    issue_valid = 1'b0;
    #2;
    tests_run++; if (pending[5] !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_pending_set: got %b expected 1", pending[5]); end
    tests_run++; if (rs1_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_busy_set: got %b expected 1", rs1_busy); end
    issue_valid = 1'b1;
    #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_waw_stall: got %b expected 0", issue_ready); end
    cycle();
    issue_valid = 1'b0;
    applyStimulus(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #2;
    tests_run++; if (src_ready !== 3'b010) begin tests_failed++; $display("[TB] FAIL sb_lsu_grant: got %b expected 010", src_ready); end
    cycle();
    applyStimulus(1, 1'b0, 5'd0, 32'h0);
    tests_run++; if ({rf_we, rf_waddr} !== {1'b1, 5'd5}) begin tests_failed++; $display("[TB] FAIL sb_wb_addr: got we=%b addr=%0d expected we=1 addr=5", rf_we, rf_waddr); end
    tests_run++; if (rf_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL sb_wb_data: got %h expected deadbeef", rf_wdata); end
    tests_run++; if (pending[5] !== 1'b1) begin tests_failed++; $display("[TB] FAIL sb_pending_hold: got %b expected 1", pending[5]); end
    issue_valid = 1'b1;
    #2;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_stall_on_clear_edge: got %b expected 0", issue_ready); end
    cycle();
    issue_valid = 1'b0;
    tests_run++; if (pending[5] !== 1'b0) begin tests_failed++; $display("[TB] FAIL sb_pending_clear: got %b expected 0", pending[5]); end
    #2;
    tests_run++; if ({issue_ready, rs1_busy, err_unexp_wb} !== 3'b100) begin tests_failed++; $display("[TB] FAIL sb_after_clear: got ready/busy/err=%b expected 100", {issue_ready, rs1_busy, err_unexp_wb}); end
  endtask

  task automatic test_collision();
    do_reset();
    applyStimulus(0, 1'b1, 5'd7, 32'h77);
    #2;
    cycle();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    #2;
    tests_run++; if ({issue_ready, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd7}) begin tests_failed++; $display("[TB] FAIL col_setup: got ready=%b we=%b addr=%0d expected 1/1/7", issue_ready, rf_we, rf_waddr); end
    cycle();
    issue_valid = 1'b0;
    tests_run++; if (pending[7] !== 1'b1) begin tests_failed++; $display("[TB] FAIL col_set_wins: got %b expected 1", pending[7]); end
    tests_run++; if (err_unexp_wb !== 1'b1) begin tests_failed++; $display("[TB] FAIL col_err: got %b expected 1", err_unexp_wb); end
    cycle();
    tests_run++; if (pending[7] !== 1'b1) begin tests_failed++; $display("[TB] FAIL col_pending_stays: got %b expected 1", pending[7]); end
  endtask

  task automatic test_x0_err();
    do_reset();
    applyStimulus(0, 1'b1, 5'd0, 32'hAA);
    #2;
    tests_run++; if (src_ready !== 3'b001) begin tests_failed++; $display("[TB] FAIL x0_ready: got %b expected 001", src_ready); end
    cycle();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    tests_run++; if ({rf_we, err_unexp_wb} !== 2'b00) begin tests_failed++; $display("[TB] FAIL x0_no_write: got we/err=%b expected 00", {rf_we, err_unexp_wb}); end
    tests_run++; if (pending !== 32'h0) begin tests_failed++; $display("[TB] FAIL x0_pending: got %h expected 0", pending); end
    applyStimulus(2, 1'b1, 5'd9, 32'h99);
    #2;
    tests_run++; if (src_ready !== 3'b100) begin tests_failed++; $display("[TB] FAIL err_grant: got %b expected 100", src_ready); end
    cycle();
    applyStimulus(2, 1'b0, 5'd0, 32'h0);
    tests_run++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin tests_failed++; $display("[TB] FAIL err_write: got we=%b addr=%0d data=%h expected 1/9/99", rf_we, rf_waddr, rf_wdata); end
    tests_run++; if (err_unexp_wb !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_set: got %b expected 1", err_unexp_wb); end
    cycle(); cycle(); cycle();
    tests_run++; if ({err_unexp_wb, rf_we} !== 2'b10) begin tests_failed++; $display("[TB] FAIL err_sticky: got err/we=%b expected 10", {err_unexp_wb, rf_we}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tests_run++; if (err_unexp_wb !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_err_cleared: got %b expected 0", err_unexp_wb); end
    issue_valid = 1'b1; issue_rd = 5'd4;
    #2;
    cycle();
    issue_valid = 1'b0;
    tests_run++; if (pending[4] !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_pending_set: got %b expected 1", pending[4]); end
    applyStimulus(0, 1'b1, 5'd4, 32'h44);
    rst = 1'b1;
    #2;
    tests_run++; if ({src_ready, issue_ready} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL mid_ready_forced: got %b expected 0000", {src_ready, issue_ready}); end
    cycle();
    rst = 1'b0;
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_we_dropped: got %b expected 0", rf_we); end
    tests_run++; if (pending !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_pending_lost: got %h expected 0", pending); end
  endtask

  task automatic test_random();
    logic [NSRC-1:0] glast;
    logic [NSRC-1:0] exp_ready;
    logic            exp_issue;
    int              g;
    do_reset();
    glast = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!src_valid[i] || glast[i])
          applyStimulus(i, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 59) == 0);
      #2;
      g         = model_grant();
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_issue = !rst && (issue_rd == 0 || !mpend[issue_rd]);
      tests_run++; if (src_ready !== exp_ready) begin tests_failed++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", n, src_ready, exp_ready); end
      tests_run++; if (issue_ready !== exp_issue) begin tests_failed++; $display("[TB] FAIL rnd_issue_ready[%0d]: got %b expected %b", n, issue_ready, exp_issue); end
      tests_run++; if ({rs1_busy, rs2_busy} !== {mpend[rs1_addr] && rs1_addr != 0, mpend[rs2_addr] && rs2_addr != 0}) begin tests_failed++; $display("[TB] FAIL rnd_busy[%0d]: got %b%b", n, rs1_busy, rs2_busy); end
      glast = exp_ready & src_valid;
      cycle();
      tests_run++; if ({rf_we, rf_waddr, rf_wdata} !== {mwe, mwaddr, mwdata}) begin tests_failed++; $display("[TB] FAIL rnd_wb[%0d]: got %b/%0d/%h expected %b/%0d/%h", n, rf_we, rf_waddr, rf_wdata, mwe, mwaddr, mwdata); end
      tests_run++; if (pending !== mpend) begin tests_failed++; $display("[TB] FAIL rnd_pending[%0d]: got %h expected %h", n, pending, mpend); end
      tests_run++; if (err_unexp_wb !== merr) begin tests_failed++; $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", n, err_unexp_wb, merr); end
    end
    rst = 1'b0;
  endtask

  initial begin
    mptr = 0; mpend = '0; merr = 1'b0; mwe = 1'b0; mwaddr = '0; mwdata = '0;
    src_valid = '0; issue_valid = 1'b0; issue_rd = '0;
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_collision();
    test_x0_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
